alu_issue_arbiter: RTL
======================

# alu_issue_arbiter

Two-requester arbiter and issue sequencer for the shared 32-bit integer ALU. Grants one of two requesters (port 0: execute lane, port 1: branch-resolve lane) per cycle, registers the operation into an issue stage that drives the external ALU, and captures the ALU result into a response stage returned with the requester ID. Sits between decode/branch logic and the single ALU instance, replacing direct ALU wiring.

## Interface
- `DATA_W`, 32: operand/result width.
- `CTRL_W`, 6: ALU control width (block = ctrl[4:3], funct3 = ctrl[2:0]).

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_ctrl` / `req1_ctrl`  in  CTRL_W  ALU control.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_W  operands.
- `alu_control`  out  CTRL_W  to ALU.
- `alu_operand_a`, `alu_operand_b`  out  DATA_W  to ALU.
- `alu_result`  in  DATA_W  from ALU (combinational).
- `alu_branch`  in  1  from ALU.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_id`  out  1  requester of this response.
- `rsp_result`  out  DATA_W  captured result.
- `rsp_branch`  out  1  captured branch flag.

## Operation
- Two-stage pipeline: S1 (issue register: valid, id, ctrl, a, b) and S2 (response register: valid, id, result, branch).
- `alu_*` outputs driven directly from S1 registers; all zero when S1 empty.
- Advance: `s2_free = !s2_valid || rsp_ready`; `s1_free = !s1_valid || s2_free`.
- Grant: only when `s1_free`. One valid requester → it wins. Both valid → requester selected by round-robin pointer `rr_ptr`.
- `reqX_ready = s1_free && grant == X`; at most one ready high per cycle. Ready may depend combinationally on both valids and `rsp_ready`.
- Handshake `reqX_valid && reqX_ready` loads S1; `rr_ptr` set to the non-granted port (`!X`). No handshake → `rr_ptr` holds.
- S1 → S2 when `s1_valid && s2_free`: S2 captures `alu_result`, `alu_branch`, id.
- `rsp_branch` is `alu_branch` captured unmodified; consumers qualify it by the ctrl block they issued.
- Requesters hold valid and payload stable until ready; payload is sampled only at handshake.
- Simultaneous S2 drain, S1 advance and new grant in one cycle are legal (full throughput, one op/cycle).

## Timing
- Reset values: `rr_ptr`=0, `s1_valid`=0, `s2_valid`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_branch`=0, `alu_*`=0, `req*_ready`=0 during reset cycle.
- Latency: handshake in cycle N → `alu_*` valid N+1 → `rsp_valid` N+2.
- Backpressure: `rsp_ready` low with S2 full freezes S2, S1 and blocks grants; nothing is dropped or overwritten.
- Reset mid-operation: in-flight S1/S2 ops discarded, no response emitted.
- `rsp_*` stable while `rsp_valid && !rsp_ready`.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin as above.
- Undefined: fixed priority, port 0 always wins on conflict; `rr_ptr` removed; port 1 starvation permitted by design.

## Structure
- Shared package: `CTRL_W`, ALU block encodings (00 arith/logic, 01 sub/shift-arith, 10 branch compare, 11 pass-through), requester ID constants `REQ_EXEC`=0, `REQ_BRANCH`=1.
- One sub-module `alu_arb_rr2`: two-input grant logic plus `rr_ptr` register (combinational grant, registered pointer update).
- ALU instantiated outside this block.

## Test plan
- Single req0 ADD, a=5, b=7, `rsp_ready`=1 → `rsp_valid` 2 cycles later, result 12, id 0.
- Both valid every cycle, round-robin → grants alternate 0,1,0,1; responses in same order, one per cycle.
- req1 branch ctrl=6'b010000 (BEQ), a=b=3 → result 1, id 1; `rsp_branch` equals ALU `alu_branch`.
- `rsp_ready` low 4 cycles with 3 issued ops → S2/S1 hold, no ready asserted, all 3 results delivered in order after release.
- Reset asserted with S1 and S2 full → next cycle all valids 0, `rr_ptr` 0; no stale response after release.
- Without `ALU_ARB_RR_EN`, both valid 5 cycles → port 0 granted all 5, `req1_ready` never high.

Source files
------------

// File: rtl/alu_issue_arbiter_pkg.sv
// Shared types and constants for the ALU issue arbiter.
// Config macro: ALU_ARB_RR_EN (round-robin on conflict; fixed priority when undefined).
package alu_issue_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 6;

  typedef enum logic [1:0] {
    BLK_ARITH     = 2'b00,
    BLK_SUB_SHIFT = 2'b01,
    BLK_BRANCH    = 2'b10,
    BLK_PASS      = 2'b11
  } alu_block_e;

  localparam logic REQ_EXEC   = 1'b0;
  localparam logic REQ_BRANCH = 1'b1;

  function automatic alu_block_e ctrl_block(input logic [CTRL_W-1:0] ctrl);
    return alu_block_e'(ctrl[4:3]);
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// Request, ALU and response signal bundle for the ALU issue arbiter.
// Config macro: ALU_ARB_RR_EN (affects arbitration only, not this bundle).
interface alu_issue_arbiter_if;
  import alu_issue_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [CTRL_W-1:0] req0_ctrl;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [CTRL_W-1:0] req1_ctrl;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_operand_a;
  logic [DATA_W-1:0] alu_operand_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_branch;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_branch;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    output req0_ready, req1_ready,
    output alu_control, alu_operand_a, alu_operand_b,
    input  alu_result, alu_branch,
    output rsp_valid, rsp_id, rsp_result, rsp_branch,
    input  rsp_ready
  );

  // Requester / ALU / consumer side
  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  alu_control, alu_operand_a, alu_operand_b,
    output alu_result, alu_branch,
    input  rsp_valid, rsp_id, rsp_result, rsp_branch,
    output rsp_ready
  );

endinterface

// File: rtl/alu_issue_arbiter_rr2.sv
// Two-input grant logic for the ALU issue arbiter (module alu_arb_rr2).
// Config macro: ALU_ARB_RR_EN selects round-robin with rr_ptr; otherwise port 0 wins.
module alu_arb_rr2 (
`ifdef ALU_ARB_RR_EN
  input  logic clock,
  input  logic reset,
`endif
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

`ifdef ALU_ARB_RR_EN
  logic rr_ptr;

  // rr_ptr names the port preferred on the next conflict
  always_comb begin
    gnt0 = en && req0 && (!req1 || !rr_ptr);
    gnt1 = en && req1 && (!req0 ||  rr_ptr);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (gnt0) begin
      rr_ptr <= 1'b1;
    end else if (gnt1) begin
      rr_ptr <= 1'b0;
    end
  end
`else
  always_comb begin
    gnt0 = en && req0;
    gnt1 = en && req1 && !req0;
  end
`endif

endmodule

// File: rtl/alu_issue_arbiter.sv
// Two-requester issue arbiter for the shared ALU: grant -> S1 issue reg -> S2 response reg.
// Config macro: ALU_ARB_RR_EN (round-robin on conflict; fixed priority when undefined).
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  alu_issue_arbiter_if.slave bus
);

  logic              s1_valid;
  logic              s1_id;
  logic [CTRL_W-1:0] s1_ctrl;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;

  logic              s2_valid;
  logic              s2_id;
  logic [DATA_W-1:0] s2_result;
  logic              s2_branch;

  logic s1_free;
  logic s2_free;
  logic gnt0;
  logic gnt1;

  assign s2_free = !s2_valid || bus.rsp_ready;
  assign s1_free = !s1_valid || s2_free;

  // Grants are suppressed during reset so no handshake can be lost to the clear
  alu_arb_rr2 u_arb (
`ifdef ALU_ARB_RR_EN
    .clock (clock),
    .reset (reset),
`endif
    .en    (s1_free && !reset),
    .req0  (bus.req0_valid),
    .req1  (bus.req1_valid),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= REQ_EXEC;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_free) begin
      s1_valid <= gnt0 || gnt1;
      if (gnt1) begin
        s1_id   <= REQ_BRANCH;
        s1_ctrl <= bus.req1_ctrl;
        s1_a    <= bus.req1_a;
        s1_b    <= bus.req1_b;
      end else if (gnt0) begin
        s1_id   <= REQ_EXEC;
        s1_ctrl <= bus.req0_ctrl;
        s1_a    <= bus.req0_a;
        s1_b    <= bus.req0_b;
      end
    end
  end

  assign bus.alu_control   = s1_valid ? s1_ctrl : '0;
  assign bus.alu_operand_a = s1_valid ? s1_a    : '0;
  assign bus.alu_operand_b = s1_valid ? s1_b    : '0;

  // Response data only moves when S2 drains, keeping rsp_* stable under backpressure
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_id     <= REQ_EXEC;
      s2_result <= '0;
      s2_branch <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_id     <= s1_id;
        s2_result <= bus.alu_result;
        s2_branch <= bus.alu_branch;
      end
    end
  end

  assign bus.rsp_valid  = s2_valid;
  assign bus.rsp_id     = s2_id;
  assign bus.rsp_result = s2_result;
  assign bus.rsp_branch = s2_branch;

endmodule
